// File: rtl/button_event_ctrl.sv
// button_event_ctrl: debounces four colour buttons and queues one event per accepted press for CPU polling.
//   clock         : system clock, rising edge
//   reset_n       : asynchronous active-low reset
//   red/blue/green/yellow_button : raw asynchronous buttons, active high
//   poll_button   : one-cycle CPU strobe, pops the head event when the queue is non-empty
//   button_out    : {ts[15:0] or 0, 8'h0, count[3:0], overflow, head colour[1:0], non-empty}
//   Optional macro BUTTON_TIMESTAMP_EN adds a cycle/1024 timestamp per event in button_out[31:16].
module button_event_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        red_button,
    input  logic        blue_button,
    input  logic        green_button,
    input  logic        yellow_button,
    input  logic        poll_button,
    output logic [31:0] button_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;
    logic [3:0]       r_sync1, r_sync2;
    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [1:0]       r_col, w_col_nx, w_col;
    logic             w_push, w_single, w_pop, w_wr, w_full, w_nonempty;
    logic [AW-1:0]    r_head, r_tail;
    logic [AW:0]      r_count;
    logic             r_ovf;
    logic [1:0]       r_mem [FIFO_DEPTH];
    logic [23:0]      w_hi;
    // Bit index of the synced vector equals the colour code.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {yellow_button, green_button, blue_button, red_button};
            r_sync2 <= r_sync1;
        end
    end
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign w_single = (r_sync2 != 4'd0) && ((r_sync2 & (r_sync2 - 4'd1)) == 4'd0);
    assign w_col    = r_sync2[1] ? 2'd1 : r_sync2[2] ? 2'd2 : r_sync2[3] ? 2'd3 : 2'd0;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_col   <= w_col_nx;
        end
    end
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_col_nx   = r_col;
        w_push     = 1'b0;
        case (r_state)
            IDLE: if (w_single) begin
                w_col_nx   = w_col;
                w_cnt_nx   = '0;
                w_state_nx = ARM;
            end
            ARM: if (w_single && w_col == r_col) begin
                if (r_cnt == LAST) begin
                    w_push     = 1'b1;
                    w_state_nx = HELD;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end else begin
                w_state_nx = IDLE;
            end
            HELD: if (r_sync2 == 4'd0) begin
                w_cnt_nx   = '0;
                w_state_nx = REL;
            end
            REL: if (r_sync2 != 4'd0) begin
                w_cnt_nx = '0;
            end else if (r_cnt == LAST) begin
                w_state_nx = IDLE;
            end else begin
                w_cnt_nx = r_cnt + 1'b1;
            end
            default: w_state_nx = IDLE;
        endcase
    end
    assign w_nonempty = r_count != '0;
    assign w_full     = r_count == (AW+1)'(FIFO_DEPTH);
    assign w_pop      = poll_button && w_nonempty;
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign w_wr       = w_push && (!w_full || w_pop);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_pop) r_head <= r_head + 1'b1;
            if (w_wr) r_tail <= r_tail + 1'b1;
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
            r_ovf   <= w_pop ? 1'b0 : (w_push && w_full) ? 1'b1 : r_ovf;
        end
    end
    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_tail] <= w_col_nx;
    end
`ifdef BUTTON_TIMESTAMP_EN
    logic [9:0]  r_div;
    logic [15:0] r_tick;
    logic [15:0] r_ts [FIFO_DEPTH];
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div  <= '0;
            r_tick <= '0;
        end else begin
            r_div  <= r_div + 1'b1;
            r_tick <= (r_div == 10'h3FF) ? r_tick + 1'b1 : r_tick;
        end
    end
    always_ff @(posedge clock) begin
        if (w_wr) r_ts[r_tail] <= r_tick;
    end
    assign w_hi = {w_nonempty ? r_ts[r_head] : 16'd0, 8'd0};
`else
    assign w_hi = 24'd0;
`endif
    assign button_out = {w_hi, 4'(r_count), r_ovf, w_nonempty ? r_mem[r_head] : 2'b00, w_nonempty};
endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
- Sits between the four raw colour buttons and the CPU's memory-mapped button read.
- Synchronises and debounces the buttons and accepts one press at a time.
- Encodes each accepted press as a colour event and queues it in a small FIFO.
- The CPU pops events with a one-cycle poll strobe, so no press is lost or read twice.

Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles a level must be stable before a press or release is accepted (10 ms at 100 MHz).
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
- FIFO_DEPTH, 4: event queue entries; power of two, 2..8.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- red_button  input  1  raw async button, active high.
- blue_button  input  1  raw async button, active high.
- green_button  input  1  raw async button, active high.
- yellow_button  input  1  raw async button, active high.
- poll_button  input  1  CPU read strobe, one cycle; pops the head event if one is present.
- button_out  output  32  head event word; format given under Behaviour.

Behaviour:
- Reset: reset_n low clears all state asynchronously: synchronisers, FSM to IDLE, counter, FIFO pointers/count, overflow flag. button_out = 0 during and after reset. Reset mid-debounce discards the pending press.
- Sync: each button passes through a 2-flop synchroniser. "single(c)" means exactly one synced button (colour c) is high.
- Colour code: red=0, blue=1, green=2, yellow=3.
- FSM, counter cnt:
  - IDLE: if single(c), latch c, cnt=0, go ARM. Two or more buttons high, or none high, stays IDLE.
  - ARM: if single(latched c) holds, cnt++. At cnt==DEBOUNCE_CYCLES-1, push c and go HELD. Any other input pattern returns to IDLE with no push.
  - HELD: stay while any button is high. When all are low, cnt=0 and go REL.
  - REL: all low, cnt++; at cnt==DEBOUNCE_CYCLES-1 go IDLE. Any button high restarts cnt=0 and stays in REL.
- Latency: a clean press stable at the pins from cycle t gives a valid button_out at cycle t+2+DEBOUNCE_CYCLES (±1).
- FIFO:
  - Push writes the colour at the tail.
  - A pop on poll_button=1 with count>0 advances the head. A poll when empty is a no-op.
  - Push while full without a same-cycle pop: the event is dropped and the sticky overflow flag is set.
  - Simultaneous push and pop when full: both proceed, no overflow, count unchanged.
  - Simultaneous push and pop when empty: push only. The event is visible next cycle.
  - Overflow clears on the next successful pop.
  - Pointers wrap modulo FIFO_DEPTH.
- button_out (combinational from registers):
  - [0] = count!=0
  - [2:1] = head colour (00 when empty)
  - [3] = overflow
  - [7:4] = count
  - [31:8] = 0 unless the optional feature is enabled

Optional Feature:
- Macro: BUTTON_TIMESTAMP_EN.
- Defined:
  - A free-running 16-bit cycle/1024 tick counter runs from reset (wraps 0xFFFF→0).
  - Each FIFO entry stores the tick value at push time.
  - button_out[31:16] = head timestamp (0 when empty).
- Undefined: no tick counter, no timestamp storage; button_out[31:8] tied to 0.

Test Plan (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4):
- Hold blue 20 cycles then release, no poll → button_out=0x13 (valid, colour 1, count 1). One poll → 0x00 next cycle.
- Red glitch high for 2 cycles → no push; button_out stays 0x00; FSM back to IDLE.
- Red and green pressed together for 20 cycles → ignored, button_out=0x00. Release green, red remains stable → one red event, 0x11.
- Five clean presses (R,B,G,Y,R), no polls → button_out=0x49 (count 4, overflow, head red); the fifth event dropped. Polls return heads R,B,G,Y; [3] clears after the first pop.
- Queue full, push and poll in the same cycle → count stays 4, [3]=0, head advances.
- Assert reset_n=0 mid-ARM with 2 events queued → button_out=0x00 immediately. After release, a fresh press gives a single event.
